gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl: RTL and testbench
========================================================

GF180MCU_FD_SC_MCU9T5V0__DLY_CAL_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl

Interface
REQ-001 SHALL have parameter NTAP, default 16: number of delay-line taps (power of two, 2..256).
REQ-002 SHALL have parameter TAP_W, default 4: tap-select width, log2(NTAP).
REQ-003 SHALL have parameter SETTLE, default 4: wait cycles after each tap change (1..255).
REQ-004 SHALL have parameter NSAMP, default 8: PD samples taken per tap (even, 2..255).
REQ-005 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port START, input, 1: calibration request, sampled in IDLE only.
REQ-008 SHALL have port PD, input, 1: phase-detector sample from delay-line output, synchronous to CLK.
REQ-009 SHALL have port MAN_EN, input, 1: manual tap override enable.
REQ-010 SHALL have port MAN_TAP, input, TAP_W: manual tap value.
REQ-011 SHALL have port TAP, output, TAP_W: registered tap select driving the delay-line mux.
REQ-012 SHALL have port BUSY, output, 1: high while calibration sweep is active.
REQ-013 SHALL have port DONE, output, 1: one-cycle pulse at end of calibration.
REQ-014 SHALL have port LOCKED, output, 1: sticky, last calibration found a tap.
REQ-015 SHALL have port FAIL, output, 1: sticky, last calibration found no tap.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE, EVAL, FINISH.
REQ-017 In IDLE with MAN_EN=1, TAP SHALL load MAN_TAP each cycle and START SHALL be ignored.
REQ-018 In IDLE with MAN_EN=0 and START=1, SHALL clear LOCKED/FAIL, set TAP=0, set BUSY=1, and enter SETTLE next cycle.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, then enter SAMPLE; the PD-ones counter is cleared on entering SETTLE.
REQ-020 SAMPLE SHALL last exactly NSAMP cycles, incrementing the ones counter on each cycle with PD=1; the counter width is wide enough to hold NSAMP and never wraps.
REQ-021 EVAL SHALL last one cycle; vote=1 iff ones > NSAMP/2 (tie counts as 0).
REQ-022 If vote=1 in EVAL: SHALL hold TAP, set LOCKED=1, and enter FINISH.
REQ-023 If vote=0 and TAP<NTAP-1: SHALL increment TAP and re-enter SETTLE.
REQ-024 If vote=0 and TAP=NTAP-1: SHALL set TAP=0, set FAIL=1, and enter FINISH; TAP never wraps through increment.
REQ-025 Each tap SHALL therefore take SETTLE+NSAMP+1 cycles.
REQ-026 FINISH SHALL last one cycle, asserting DONE=1 and BUSY=0, then return to IDLE.
REQ-027 START, MAN_EN, and MAN_TAP SHALL be ignored outside IDLE; calibration is not abortable except by RST.
REQ-028 START held high through FINISH SHALL start a new sweep on the first IDLE cycle.
REQ-029 LOCKED and FAIL SHALL never both be 1; both SHALL hold until the next accepted START or RST.
REQ-030 TAP SHALL remain at the locked value in IDLE until MAN_EN=1 or a new START is accepted.

Reset
REQ-031 RST=1 at a clock edge SHALL force state=IDLE, TAP=0, BUSY=0, DONE=0, LOCKED=0, FAIL=0, and counters=0, from any state.
REQ-032 RST SHALL take priority over START and MAN_EN in the same cycle; the first operation is accepted in the cycle after RST deasserts.

Verification
REQ-033 Lock test (defaults): START at edge k; PD=1 whenever TAP>=5 -> BUSY=1 from k+1; DONE pulse at k+79; TAP=5; LOCKED=1, FAIL=0.
REQ-034 Fail test: PD=0 constantly; START -> TAP sweeps 0..15; DONE at k+209; TAP=0; FAIL=1, LOCKED=0.
REQ-035 Majority tie test: PD=1 on exactly 4 of 8 SAMPLE cycles at tap 0, and 5 of 8 at tap 1 -> tap 0 rejected; lock at TAP=1; DONE at k+27.
REQ-036 Manual override test: IDLE, MAN_EN=1, MAN_TAP=9 -> TAP=9 the next cycle; START ignored; BUSY stays 0.
REQ-037 Mid-sweep reset test: RST at the SAMPLE cycle of tap 3 -> all outputs 0 the next cycle; START after release restarts from TAP=0.
REQ-038 Busy-ignore test: during a sweep, pulse START and toggle MAN_EN/MAN_TAP -> sweep timing and result are identical to REQ-033.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl.sv - delay-line tap calibration sweep controller
module gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl #(
    parameter int NTAP   = 16,
    parameter int TAP_W  = 4,
    parameter int SETTLE = 4,
    parameter int NSAMP  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             PD,
    input  logic             MAN_EN,
    input  logic [TAP_W-1:0] MAN_TAP,
    output logic [TAP_W-1:0] TAP,
    output logic             BUSY,
    output logic             DONE,
    output logic             LOCKED,
    output logic             FAIL
);

    // ones counter must hold NSAMP itself so a full run of PD=1 never wraps
    localparam int OW = $clog2(NSAMP + 1);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]       SAMP_LAST   = 8'(NSAMP - 1);
    localparam logic [OW-1:0]    HALF        = OW'(NSAMP / 2);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(NTAP - 1);

    typedef enum logic [2:0] {
        s_idle,
        s_settle,
        s_sample,
        s_eval,
        s_finish
    } state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic [OW-1:0] ones;

    // sweep FSM: settle, sample, majority-vote each tap in turn; all outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= s_idle;
            cnt    <= '0;
            ones   <= '0;
            TAP    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            LOCKED <= 1'b0;
            FAIL   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                s_idle: begin
                    if (MAN_EN) begin
                        TAP <= MAN_TAP;
                    end else if (START) begin
                        LOCKED <= 1'b0;
                        FAIL   <= 1'b0;
                        TAP    <= '0;
                        BUSY   <= 1'b1;
                        cnt    <= '0;
                        ones   <= '0;
                        state  <= s_settle;
                    end
                end
                s_settle: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= s_sample;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                s_sample: begin
                    if (PD) begin
                        ones <= ones + OW'(1);
                    end
                    if (cnt == SAMP_LAST) begin
                        cnt   <= '0;
                        state <= s_eval;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                s_eval: begin
                    // strict majority; an exact tie rejects the tap
                    if (ones > HALF) begin
                        LOCKED <= 1'b1;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        state  <= s_finish;
                    end else if (TAP != TAP_MAX) begin
                        TAP   <= TAP + TAP_W'(1);
                        ones  <= '0;
                        state <= s_settle;
                    end else begin
                        TAP   <= '0;
                        FAIL  <= 1'b1;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= s_finish;
                    end
                end
                s_finish: begin
                    state <= s_idle;
                end
                default: begin
                    state <= s_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl.sv - scoreboard bench for the tap calibration controller
module tb_gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl;

    localparam int NTAP  = 16;
    localparam int SETL  = 4;
    localparam int NS    = 8;
    localparam int TPT   = SETL + NS + 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       PD = 1'b0;
    logic       MAN_EN = 1'b0;
    logic [3:0] MAN_TAP = 4'd0;
    logic [3:0] TAP;
    logic       BUSY, DONE, LOCKED, FAIL;

    gf180mcu_fd_sc_mcu9t5v0__dly_cal_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .PD(PD), .MAN_EN(MAN_EN), .MAN_TAP(MAN_TAP),
        .TAP(TAP), .BUSY(BUSY), .DONE(DONE), .LOCKED(LOCKED), .FAIL(FAIL)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int done_at;
        int tap;
        bit locked;
        bit fail;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] masks[NTAP];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // monitor: every DONE pulse is matched against the oldest expected outcome
    logic prev_done = 1'b0;
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (prev_done) chk("done_width", 2, 1);
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc + 1, e.done_at);
                chk("done_tap", int'(TAP), e.tap);
                chk("done_locked", int'(LOCKED), int'(e.locked));
                chk("done_fail", int'(FAIL), int'(e.fail));
                chk("done_busy", int'(BUSY), 0);
            end
        end
        prev_done = DONE;
    end

    // one sweep: model predicts the outcome from tap vote counts, driver plays PD by schedule
    task automatic sweep(input int rst_rel, input bit noise, input bit hold);
        int k, lock_t, total, t, j;
        lock_t = -1;
        for (int i = 0; i < NTAP; i++) begin
            if (lock_t < 0 && $countones(masks[i]) > NS / 2) lock_t = i;
        end
        total = (lock_t >= 0) ? TPT * (lock_t + 1) + 1 : TPT * NTAP + 1;
        @(negedge CLK);
        START  = 1'b1;
        MAN_EN = 1'b0;
        k = cyc + 1;
        if (rst_rel < 0) begin
            exp_t e;
            e.done_at = k + total;
            e.tap     = (lock_t >= 0) ? lock_t : 0;
            e.locked  = (lock_t >= 0);
            e.fail    = (lock_t < 0);
            exp_q.push_back(e);
        end
        for (int rel = 1; rel <= total; rel++) begin
            @(negedge CLK);
            if (rel == 1) chk("busy_after_start", int'(BUSY), 1);
            if (noise && rel < total) begin
                START   = 1'($urandom);
                MAN_EN  = 1'($urandom);
                MAN_TAP = 4'($urandom);
            end else begin
                START  = hold && rel >= total - 2;
                MAN_EN = 1'b0;
            end
            t = (rel - 5) / TPT;
            j = (rel - 5) % TPT;
            if (rel >= 5 && t < NTAP && j < NS) PD = masks[t][j];
            else PD = 1'($urandom);
            if (rel == rst_rel) begin
                RST = 1'b1;
                START = 1'b0;
                MAN_EN = 1'b0;
                @(negedge CLK);
                chk("rst_tap", int'(TAP), 0);
                chk("rst_busy", int'(BUSY), 0);
                chk("rst_done", int'(DONE), 0);
                chk("rst_locked", int'(LOCKED), 0);
                chk("rst_fail", int'(FAIL), 0);
                RST = 1'b0;
                return;
            end
        end
    endtask

    task automatic set_lock_at(input int n);
        for (int i = 0; i < NTAP; i++) masks[i] = (i >= n) ? 8'hFF : 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, pending=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge CLK);
        START = 1'b1;
        MAN_EN = 1'b1;
        chk("reset_tap", int'(TAP), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_done", int'(DONE), 0);
        chk("reset_locked", int'(LOCKED), 0);
        chk("reset_fail", int'(FAIL), 0);
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        MAN_EN = 1'b0;
        @(negedge CLK);

        // lock at tap 5, then the tap must hold in idle
        set_lock_at(5);
        sweep(-1, 1'b0, 1'b0);
        START = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("hold_locked_tap", int'(TAP), 5);
        end

        // manual override in idle ignores START
        MAN_EN = 1'b1;
        MAN_TAP = 4'd9;
        START = 1'b1;
        @(negedge CLK);
        chk("manual_tap", int'(TAP), 9);
        chk("manual_busy", int'(BUSY), 0);
        MAN_TAP = 4'd2;
        @(negedge CLK);
        chk("manual_tap2", int'(TAP), 2);
        chk("manual_busy2", int'(BUSY), 0);
        MAN_EN = 1'b0;
        START = 1'b0;
        @(negedge CLK);

        // no tap ever passes
        set_lock_at(NTAP + 1);
        sweep(-1, 1'b0, 1'b0);
        START = 1'b0;
        @(negedge CLK);

        // tie at tap 0 is rejected, 5 of 8 at tap 1 locks
        set_lock_at(NTAP + 1);
        masks[0] = 8'h0F;
        masks[1] = 8'h1F;
        sweep(-1, 1'b0, 1'b0);
        START = 1'b0;
        @(negedge CLK);

        // reset during the sample window of tap 3, then a clean restart
        set_lock_at(NTAP + 1);
        sweep(3 * TPT + 6, 1'b0, 1'b0);
        @(negedge CLK);
        set_lock_at(5);
        sweep(-1, 1'b0, 1'b0);
        START = 1'b0;
        @(negedge CLK);

        // inputs toggling mid-sweep must not disturb timing or result
        sweep(-1, 1'b1, 1'b0);
        START = 1'b0;
        MAN_EN = 1'b0;
        @(negedge CLK);

        // randomized sweeps, chained by holding START through FINISH
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NTAP; i++)
                masks[i] = (n < 3) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            sweep(-1, n[0], n < 5);
        end
        START = 1'b0;
        MAN_EN = 1'b0;

        repeat (5) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
